// File: rtl/rega_multizona_pkg.sv
// Shared types and constants for the multi-zone irrigation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rega_multizona_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REGA,
        ST_MIST,
        ST_LIMP
    } state_e;

    localparam logic [1:0] NV_EMPTY = 2'b00;
    localparam logic [1:0] NV_FULL  = 2'b11;

    localparam int T_ASP_DEF  = 15;
    localparam int T_GOT_DEF  = 30;
    localparam int T_MIST_DEF = 8;
    localparam int T_LIMP_DEF = 6;

endpackage

// File: rtl/rega_multizona_if.sv
// Sensor/actuator bundle between the irrigation controller and the plant.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or one-cycle strobes.
interface rega_multizona_if #(
    parameter int N_ZONES = 4,
    parameter int TW      = 8
);
    localparam int ZW = $clog2(N_ZONES);

    logic               Tick;
    logic [N_ZONES-1:0] Us;
    logic [N_ZONES-1:0] Modo;
    logic [1:0]         Nv;
    logic               Adub;

    logic               A;
    logic               G;
    logic               Ve;
    logic               Mist;
    logic               Limp;
    logic [N_ZONES-1:0] Zone_en;
    logic [ZW-1:0]      Zone_id;
    logic [TW-1:0]      Cnt;
    logic               Busy;

    modport master (
        output Tick, Us, Modo, Nv, Adub,
        input  A, G, Ve, Mist, Limp, Zone_en, Zone_id, Cnt, Busy
    );

    modport slave (
        input  Tick, Us, Modo, Nv, Adub,
        output A, G, Ve, Mist, Limp, Zone_en, Zone_id, Cnt, Busy
    );
endinterface

// File: rtl/rega_multizona_rr.sv
// Round-robin zone picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_arbiter_rega #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld
);
    localparam int IW = $clog2(N);

    // Scan farthest-first so the candidate nearest to ptr is written last and wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (req[sel]) begin
                gnt_idx = sel;
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rega_multizona.sv
// Irrigation controller: tank fill, round-robin zone watering, fertilizer mix and line flush.
// Latency: one Clk from input condition to registered actuator change.
// Backpressure: none; pending zone requests simply wait while the FSM is busy.
module rega_multizona
    import rega_multizona_pkg::*;
#(
    parameter int N_ZONES = 4,
    parameter int TW      = 8,
    parameter int T_ASP   = T_ASP_DEF,
    parameter int T_GOT   = T_GOT_DEF,
    parameter int T_MIST  = T_MIST_DEF,
    parameter int T_LIMP  = T_LIMP_DEF
) (
    input logic             Clk,
    input logic             Rst,
    rega_multizona_if.slave io
);
    localparam int ZW = $clog2(N_ZONES);

    localparam logic [TW-1:0] D_ASP  = TW'(T_ASP);
    localparam logic [TW-1:0] D_GOT  = TW'(T_GOT);
    localparam logic [TW-1:0] D_MIST = TW'(T_MIST);
    localparam logic [TW-1:0] D_LIMP = TW'(T_LIMP);

    state_e               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [ZW-1:0]        zone_q, zone_d;
    logic [ZW-1:0]        ptr_q, ptr_d;
    logic                 mode_q, mode_d;
    logic                 a_q, a_d, g_q, g_d, ve_q, ve_d;
    logic                 mist_q, mist_d, limp_q, limp_d;
    logic [N_ZONES-1:0]   zone_en_q, zone_en_d;

    logic [ZW-1:0]        gnt_idx;
    logic                 gnt_vld;
    logic                 expire;
    logic [TW-1:0]        cnt_dec;

    rr_arbiter_rega #(.N(N_ZONES)) u_arb (
        .req     (io.Us),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zone_d  = zone_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        expire  = (cnt_q == '0) || ((cnt_q == TW'(1)) && io.Tick);
        cnt_dec = io.Tick ? (cnt_q - TW'(1)) : cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (io.Nv == NV_EMPTY) begin
                    state_d = ST_FILL;
                end else if (io.Adub) begin
                    state_d = ST_MIST;
                    cnt_d   = D_MIST;
                end else if (gnt_vld) begin
                    state_d = ST_REGA;
                    zone_d  = gnt_idx;
                    mode_d  = io.Modo[gnt_idx];
                    cnt_d   = io.Modo[gnt_idx] ? D_ASP : D_GOT;
                end
            end
            ST_FILL: begin
                if (io.Nv == NV_FULL) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REGA: begin
                // An empty-tank abort leaves ptr alone so the same zone is retried first.
                if (io.Nv == NV_EMPTY) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end else if (expire || (io.Tick && !io.Us[zone_q])) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = (zone_q == ZW'(N_ZONES - 1)) ? '0 : zone_q + ZW'(1);
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_MIST: begin
                if (expire) begin
                    state_d = ST_LIMP;
                    cnt_d   = D_LIMP;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_LIMP: begin
                if (expire) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Actuators follow the next state so they change on the same edge as the FSM.
        a_d       = (state_d == ST_REGA) && mode_d;
        g_d       = (state_d == ST_REGA) && !mode_d;
        ve_d      = (state_d == ST_FILL);
        mist_d    = (state_d == ST_MIST);
        limp_d    = (state_d == ST_LIMP);
        zone_en_d = (state_d == ST_REGA) ? ({{(N_ZONES-1){1'b0}}, 1'b1} << zone_d) : '0;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            zone_q    <= '0;
            ptr_q     <= '0;
            mode_q    <= 1'b0;
            a_q       <= 1'b0;
            g_q       <= 1'b0;
            ve_q      <= 1'b0;
            mist_q    <= 1'b0;
            limp_q    <= 1'b0;
            zone_en_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            zone_q    <= zone_d;
            ptr_q     <= ptr_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            g_q       <= g_d;
            ve_q      <= ve_d;
            mist_q    <= mist_d;
            limp_q    <= limp_d;
            zone_en_q <= zone_en_d;
        end
    end

    assign io.A       = a_q;
    assign io.G       = g_q;
    assign io.Ve      = ve_q;
    assign io.Mist    = mist_q;
    assign io.Limp    = limp_q;
    assign io.Zone_en = zone_en_q;
    assign io.Zone_id = zone_q;
    assign io.Cnt     = cnt_q;
    assign io.Busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_rega_multizona.sv
// Bench for rega_multizona: directed scenarios plus random traffic against a phase-level model.
module tb_rega_multizona;
    localparam int N      = 4;
    localparam int TW     = 8;
    localparam int T_ASP  = 15;
    localparam int T_GOT  = 30;
    localparam int T_MIST = 8;
    localparam int T_LIMP = 6;

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_IRR   = 2;
    localparam int P_MIX   = 3;
    localparam int P_CLEAN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rega_multizona_if #(.N_ZONES(N), .TW(TW)) bus ();

    rega_multizona #(
        .N_ZONES (N),
        .TW      (TW),
        .T_ASP   (T_ASP),
        .T_GOT   (T_GOT),
        .T_MIST  (T_MIST),
        .T_LIMP  (T_LIMP)
    ) dut (
        .Clk (clk),
        .Rst (rst_n),
        .io  (bus)
    );

    always #5 clk = ~clk;

    // Model: current phase, ticks left, zone in service, its mode, next zone to look at first.
    int ph, left, zone, sprk, next_z;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; left = 0; zone = 0; sprk = 0; next_z = 0;
    endtask

    task automatic model_step();
        int  nv;
        int  z;
        bit  tk;
        bit  found;
        nv = int'(bus.Nv);
        tk = bus.Tick;
        found = 0;
        if (ph == P_IDLE) begin
            if (nv == 0) ph = P_FILL;
            else if (bus.Adub) begin ph = P_MIX; left = T_MIST % (1 << TW); end
            else begin
                for (int k = 0; k < N; k++) begin
                    z = (next_z + k) % N;
                    if (!found && bus.Us[z]) begin
                        found = 1;
                        ph = P_IRR; zone = z; sprk = bus.Modo[z] ? 1 : 0;
                        left = (sprk == 1 ? T_ASP : T_GOT) % (1 << TW);
                    end
                end
            end
        end else if (ph == P_FILL) begin
            if (nv == 3) ph = P_IDLE;
        end else if (ph == P_IRR) begin
            if (nv == 0) begin ph = P_FILL; left = 0; end
            else if (left == 0 || (tk && (left == 1 || !bus.Us[zone]))) begin
                ph = P_IDLE; left = 0; next_z = (zone + 1) % N;
            end else if (tk) left--;
        end else if (ph == P_MIX) begin
            if (left == 0 || (tk && left == 1)) begin ph = P_CLEAN; left = T_LIMP % (1 << TW); end
            else if (tk) left--;
        end else begin
            if (left == 0 || (tk && left == 1)) begin ph = P_IDLE; left = 0; end
            else if (tk) left--;
        end
    endtask

    task automatic compare_all();
        check_eq("A",       32'(bus.A),       (ph == P_IRR && sprk == 1) ? 1 : 0);
        check_eq("G",       32'(bus.G),       (ph == P_IRR && sprk == 0) ? 1 : 0);
        check_eq("Ve",      32'(bus.Ve),      (ph == P_FILL) ? 1 : 0);
        check_eq("Mist",    32'(bus.Mist),    (ph == P_MIX) ? 1 : 0);
        check_eq("Limp",    32'(bus.Limp),    (ph == P_CLEAN) ? 1 : 0);
        check_eq("Zone_en", 32'(bus.Zone_en), (ph == P_IRR) ? (1 << zone) : 0);
        check_eq("Zone_id", 32'(bus.Zone_id), zone);
        check_eq("Cnt",     32'(bus.Cnt),     left);
        check_eq("Busy",    32'(bus.Busy),    (ph != P_IDLE) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        compare_all();
    endtask

    // Called just after an edge; reset lands mid-cycle to exercise the asynchronous path.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_busy", 32'(bus.Busy), 0);
        check_eq("rst_cnt",  32'(bus.Cnt),  0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        int r;
        order = '{0, 1, 2, 3, 0};
        bus.Tick = 1'b0; bus.Us = '0; bus.Modo = '0; bus.Nv = 2'b11; bus.Adub = 1'b0;
        model_reset();
        #3;
        compare_all();
        @(posedge clk); #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Empty tank: fill first, then serve zone 0.
        bus.Nv = 2'b00; bus.Us = 4'b0001;
        cycle();
        check_eq("s1_ve", 32'(bus.Ve), 1);
        cycle(); cycle();
        bus.Nv = 2'b11;
        cycle();
        check_eq("s1_idle", 32'(bus.Busy), 0);
        cycle();
        check_eq("s1_zone_en", 32'(bus.Zone_en), 1);
        check_eq("s1_drip", 32'(bus.G), 1);
        bus.Us = '0; bus.Tick = 1'b1;
        cycle();
        check_eq("s1_early_exit", 32'(bus.Busy), 0);

        // Sprinkler run on zone 2.
        bus.Tick = 1'b0; bus.Us = 4'b0100; bus.Modo = 4'b0100;
        cycle();
        check_eq("s2_zone_en", 32'(bus.Zone_en), 4);
        check_eq("s2_pump", 32'(bus.A), 1);
        check_eq("s2_cnt", 32'(bus.Cnt), 15);
        bus.Tick = 1'b1;
        repeat (14) cycle();
        check_eq("s2_cnt_last", 32'(bus.Cnt), 1);
        bus.Modo = 4'b0000;
        cycle();
        check_eq("s2_done", 32'(bus.Busy), 0);
        bus.Us = '0;
        cycle();

        // Round-robin across all drip zones.
        async_reset();
        bus.Us = 4'b1111; bus.Modo = '0; bus.Tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("s3_zone", 32'(bus.Zone_id), order[i]);
            check_eq("s3_cnt", 32'(bus.Cnt), 30);
            repeat (30) cycle();
            check_eq("s3_served", 32'(bus.Busy), 0);
        end
        bus.Us = '0;
        cycle();

        // Fertilizer mix and flush hold off a pending zone.
        async_reset();
        bus.Adub = 1'b1; bus.Us = 4'b0010; bus.Tick = 1'b1;
        cycle();
        check_eq("s4_mist", 32'(bus.Mist), 1);
        check_eq("s4_cnt", 32'(bus.Cnt), 8);
        bus.Adub = 1'b0;
        repeat (7) cycle();
        bus.Adub = 1'b1;
        cycle();
        check_eq("s4_limp", 32'(bus.Limp), 1);
        check_eq("s4_limp_cnt", 32'(bus.Cnt), 6);
        repeat (5) cycle();
        check_eq("s4_limp_hold", 32'(bus.Limp), 1);
        bus.Adub = 1'b0;
        cycle();
        check_eq("s4_idle", 32'(bus.Busy), 0);
        cycle();
        check_eq("s4_zone_en", 32'(bus.Zone_en), 2);
        bus.Us = '0;
        cycle();

        // Tank empties mid-irrigation on zone 2.
        bus.Us = 4'b0100; bus.Modo = '0; bus.Tick = 1'b0;
        cycle();
        check_eq("s5_cnt", 32'(bus.Cnt), 30);
        bus.Tick = 1'b1;
        repeat (10) cycle();
        check_eq("s5_cnt20", 32'(bus.Cnt), 20);
        bus.Nv = 2'b00;
        cycle();
        check_eq("s5_fill", 32'(bus.Ve), 1);
        check_eq("s5_valve_off", 32'(bus.Zone_en), 0);
        bus.Nv = 2'b11;
        cycle();
        cycle();
        check_eq("s5_zone", 32'(bus.Zone_id), 2);
        check_eq("s5_reload", 32'(bus.Cnt), 30);
        bus.Us = '0;
        cycle();

        // Reset during MIST, then zone 3 found from pointer 0.
        bus.Adub = 1'b1; bus.Tick = 1'b1;
        cycle();
        check_eq("s6_mist", 32'(bus.Mist), 1);
        bus.Adub = 1'b0;
        repeat (3) cycle();
        async_reset();
        check_eq("s6_mist_off", 32'(bus.Mist), 0);
        bus.Us = 4'b1000; bus.Tick = 1'b0;
        cycle();
        check_eq("s6_zone", 32'(bus.Zone_id), 3);
        check_eq("s6_zone_en", 32'(bus.Zone_en), 8);
        bus.Us = '0;
        cycle();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            bus.Tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) bus.Us = 4'($urandom);
            if ($urandom_range(0, 4) == 0) bus.Modo = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 9);
                bus.Nv = (r == 0) ? 2'b00 : (r < 3) ? 2'($urandom_range(1, 2)) : 2'b11;
            end
            bus.Adub = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) async_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rega_multizona.md
REGA_MULTIZONA -- requirements
Module: rega_multizona

Interface
REQ-001 Parameters SHALL be: N_ZONES, default 4, number of irrigation zones (2..16).
REQ-002 Parameters SHALL include: TW, default 8, countdown width in bits.
REQ-003 Parameters SHALL include: T_ASP, default 15, sprinkler duration in ticks; T_GOT, default 30, drip duration in ticks.
REQ-004 Parameters SHALL include: T_MIST, default 8, fertilizer mix duration in ticks; T_LIMP, default 6, line-cleaning duration in ticks.
REQ-005 Ports SHALL be as follows:
- Clk  in  1  system clock; all flops on the rising edge.
- Rst  in  1  asynchronous reset, active-low.
- Tick  in  1  one-Clk timing strobe from the clock divider.
- Us  in  N_ZONES  per-zone dry-soil request, 1 = dry.
- Modo  in  N_ZONES  per-zone mode, 1 = sprinkler, 0 = drip.
- Nv  in  2  tank level: 00 = empty, 01 = low, 10 = mid, 11 = full.
- Adub  in  1  fertilizer request, level-sensitive.
- A  out  1  sprinkler pump.
- G  out  1  drip pump.
- Ve  out  1  tank inlet valve.
- Mist  out  1  mixer.
- Limp  out  1  cleaning flush.
- Zone_en  out  N_ZONES  one-hot zone valve.
- Zone_id  out  clog2(N_ZONES)  active or last-served zone.
- Cnt  out  TW  remaining ticks in the current timed state.
- Busy  out  1  FSM not in IDLE.

Function
REQ-006 The FSM SHALL have exactly five states: IDLE, FILL, REGA, MIST, LIMP.
REQ-007 From IDLE, evaluated every Clk, the FSM SHALL take the first matching transition in priority order:
- Nv==00 -> FILL.
- Adub==1 -> MIST, Cnt=T_MIST.
- Any Us bit set -> REGA on the arbitrated zone, Cnt=T_ASP or T_GOT per that zone's Modo bit.
REQ-008 Arbitration SHALL be round-robin: search starts at (last served zone + 1) mod N_ZONES and wraps; after reset the search starts at zone 0.
REQ-009 In FILL, Ve SHALL be 1; the FSM SHALL stay in FILL until Nv==11, then return to IDLE.
REQ-010 In REGA, Zone_en SHALL be the one-hot of the selected zone.
REQ-011 In REGA, A SHALL be 1 if the zone's Modo bit latched at entry is 1, otherwise G SHALL be 1; a Modo change mid-irrigation SHALL NOT take effect.
REQ-012 In each timed state, Cnt SHALL decrement by 1 on each Clk with Tick=1 and SHALL NOT go below 0.
REQ-013 Each timed state SHALL exit on the Clk where Cnt==1 and Tick==1, or where Cnt==0.
REQ-014 REGA SHALL exit early on the next Tick if the zone's Us bit has dropped, and SHALL exit immediately to FILL if Nv==00; a zone aborted for an empty tank SHALL NOT be marked served.
REQ-015 MIST SHALL assert Mist and go to LIMP with Cnt=T_LIMP on expiry; LIMP SHALL assert Limp and return to IDLE on expiry.
REQ-016 No zone SHALL be irrigated during MIST or LIMP; Us requests SHALL be held and serviced afterwards.
REQ-017 A Adub re-assert during MIST or LIMP SHALL be ignored.
REQ-018 A, G, Ve, Mist, Limp and Zone_en SHALL be registered, mutually exclusive per state, and all 0 in IDLE.
REQ-019 Durations SHALL be truncated to TW bits; a zero duration SHALL cause exit on the first Clk of the state.
REQ-020 Tick and state-entry arriving on the same Clk: the entry load SHALL win and no decrement SHALL occur.
REQ-021 Busy SHALL equal (state != IDLE).

Reset
REQ-022 While Rst is 0, the state SHALL be IDLE; Cnt, Zone_id, Zone_en, A, G, Ve, Mist, Limp and Busy SHALL all be 0; the round-robin pointer SHALL be zone 0.
REQ-023 Reset asserted mid-operation SHALL de-energise all actuators asynchronously, with no completion of the current state.

Structure
REQ-024 A shared package SHALL hold the state enum, the Nv level constants (NV_EMPTY, NV_FULL) and default durations.
REQ-025 The round-robin selector SHALL be a sub-module, rr_arbiter_rega (request vector and pointer in; grant index and valid out).

Verification
REQ-026 Scenario, empty tank: reset, Nv=00, Us=0001 -> FILL with Ve=1; set Nv=11 -> IDLE, then REGA on zone 0.
REQ-027 Scenario, sprinkler run: Nv=11, Us=0100, Modo=0100 -> Zone_en=0100, A=1, Cnt=15, returning to IDLE after 15 Ticks.
REQ-028 Scenario, round-robin: Us=1111 held, drip on all zones -> zones served in order 0,1,2,3,0, each for 30 Ticks.
REQ-029 Scenario, fertilizer blocks irrigation: Adub=1 with Us=0010 -> MIST for 8 Ticks, LIMP for 6 Ticks, then REGA on zone 1.
REQ-030 Scenario, tank empties mid-irrigation: Nv drops to 00 during REGA on zone 2 at Cnt=20 -> FILL on the next Clk; after Nv=11, zone 2 is served again with Cnt=T_GOT.
REQ-031 Scenario, reset mid-operation: Rst=0 during MIST -> all outputs 0 immediately; after release, Us=1000 is served first by zone 3 from pointer 0.
